// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// The master modport is the fetch stage; slave is memory/decode/branch unit.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_fault, fetch_cnt,
    input  imem_ready, imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_fault, fetch_cnt,
    output imem_ready, imem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: one outstanding word read, a single-entry output
// register toward decode, and redirect handling with a sticky misalignment fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {StFetch, StHold, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    cnt_d    = cnt_q;

    if (state_q != StFault && bus.redirect) begin
      // Redirect wins over a same-cycle response or accept; both are wrong-path.
      if (bus.redirect_pc[1:0] == 2'b00) begin
        pc_d    = bus.redirect_pc;
        state_d = StFetch;
      end else begin
        state_d = StFault;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (bus.imem_ready) begin
            instr_d  = bus.imem_rdata;
            out_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = StHold;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            cnt_d   = cnt_q + 32'd1;
            state_d = StFetch;
          end
        end
        StFault: ;
        default: state_d = StFault;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      out_pc_q <= 32'h0;
      cnt_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.imem_req    = (state_q == StFetch);
  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = (state_q == StHold);
  assign bus.out_instr   = instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.fetch_fault = (state_q == StFault);
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, each cycle
// checked against a transaction-level model of the fetch stage.
module tb_instr_fetch;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: next fetch address, optional held instruction, fault flag, delivery count.
  logic [31:0] m_pc;
  bit          m_have;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_fault;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, !m_fault && !m_have});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", {31'h0, bus.out_valid}, {31'h0, !m_fault && m_have});
    chk("out_instr", bus.out_instr, m_instr);
    chk("out_pc", bus.out_pc, m_ipc);
    chk("fetch_fault", {31'h0, bus.fetch_fault}, {31'h0, m_fault});
    chk("fetch_cnt", bus.fetch_cnt, m_cnt);
  endtask

  // One clock: drive inputs, advance the model on the same edge, check after it.
  task automatic step(input bit r, input bit rdy, input logic [31:0] rdata, input bit ordy,
                      input bit redir, input logic [31:0] rpc);
    rst             = r;
    bus.imem_ready  = rdy;
    bus.imem_rdata  = rdata;
    bus.out_ready   = ordy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (r) begin
      m_pc = ResetPc; m_have = 0; m_fault = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
    end else if (m_fault) begin
      // stuck until reset
    end else if (redir) begin
      if (rpc % 4 == 0) begin
        m_pc   = rpc;
        m_have = 0;
      end else begin
        m_fault = 1;
      end
    end else if (!m_have) begin
      if (rdy) begin
        m_instr = rdata;
        m_ipc   = m_pc;
        m_pc    = m_pc + 4;
        m_have  = 1;
      end
    end else if (ordy) begin
      m_cnt  = m_cnt + 1;
      m_have = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    bus.imem_ready = 0; bus.imem_rdata = 0; bus.out_ready = 0;
    bus.redirect = 0; bus.redirect_pc = 0;
    #2;

    // Reset.
    step(1, 0, 0, 0, 0, 0);
    chk("reset_addr", bus.imem_addr, ResetPc);

    // Zero-wait stream of NOPs: 0, 4, 8 delivered on alternating cycles.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h0000_0013, 1, 0, 0);
      if (i % 2 == 0) chk("nop_pc", bus.out_pc, 32'(i * 2));
    end
    chk("cnt_after_3", bus.fetch_cnt, 32'd3);
    step(0, 1, 32'h0000_0013, 1, 0, 0);
    step(0, 1, 32'h0000_0013, 1, 0, 0);

    // Wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'hDEAD_BEEF, 1, 0, 0);
      chk("wait_addr", bus.imem_addr, 32'h10);
    end
    step(0, 1, 32'h00A0_0093, 0, 0, 0);
    chk("wait_instr", bus.out_instr, 32'h00A0_0093);
    chk("wait_pc", bus.out_pc, 32'h10);

    // Backpressure: held outputs stable, no request.
    held_instr = bus.out_instr;
    held_pc    = bus.out_pc;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h1234_5678, 0, 0, 0);
      chk("bp_instr", bus.out_instr, held_instr);
      chk("bp_pc", bus.out_pc, held_pc);
      chk("bp_cnt", bus.fetch_cnt, 32'd4);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("bp_accept_cnt", bus.fetch_cnt, 32'd5);

    // Redirect coinciding with a memory response.
    step(0, 1, 32'hCAFE_0001, 0, 1, 32'h100);
    chk("redir_fetch_addr", bus.imem_addr, 32'h100);
    // Redirect while holding with out_ready: instruction killed, not counted.
    step(0, 1, 32'hCAFE_0002, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h100);
    chk("redir_hold_addr", bus.imem_addr, 32'h100);
    chk("redir_hold_cnt", bus.fetch_cnt, 32'd5);

    // PC wrap.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 32'h0000_0013, 0, 0, 0);
    chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Reset mid-hold drops the held instruction and the count.
    step(0, 1, 32'h0000_0013, 0, 0, 0);
    step(1, 1, 32'h0000_0013, 1, 0, 0);
    chk("rst_hold_cnt", bus.fetch_cnt, 32'd0);

    // Random traffic with occasional redirects, misaligned targets and resets.
    for (int i = 0; i < 3000; i++) begin
      bit          r, rdy, ordy, redir;
      logic [31:0] rpc;
      r     = ($urandom_range(0, 199) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 9) == 0);
      rpc   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(r, rdy, $urandom, ordy, redir, rpc);
    end

    // Misaligned redirect faults permanently until reset.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0013, 1, 1, 32'h102);
    chk("fault_flag", {31'h0, bus.fetch_fault}, 32'h1);
    chk("fault_addr", bus.imem_addr, ResetPc);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h0000_0013, 1, 1, 32'h200);
      chk("fault_req", {31'h0, bus.imem_req}, 32'h0);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("fault_rst_addr", bus.imem_addr, ResetPc);
    chk("fault_rst_flag", {31'h0, bus.fetch_fault}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-issue RV32 datapath. It owns the program counter and issues one word-aligned read at a time to instruction memory. It holds the returned word in an output register and presents it, with its PC, to the decode stage (control decoder and immediate generator) through a valid/ready handshake. Branch and jump targets computed downstream redirect it.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  byte address of the requested word.
- imem_ready  input  1  read completes this cycle; imem_rdata valid.
- imem_rdata  input  32  instruction word for imem_addr.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the held instruction this cycle.
- out_instr  output  32  fetched instruction word.
- out_pc  output  32  address of out_instr.
- redirect  input  1  discard the current path and fetch from redirect_pc.
- redirect_pc  input  32  new fetch address (branch/jump target).
- fetch_fault  output  1  sticky: a misaligned redirect target was received.
- fetch_cnt  output  32  number of instructions delivered to decode.

## Operation
- Registers: pc, state, instr_q, pc_q, fetch_cnt. States: FETCH, HOLD, FAULT.
- Combinational outputs: imem_req = (state==FETCH); imem_addr = pc; out_valid = (state==HOLD); out_instr = instr_q; out_pc = pc_q; fetch_fault = (state==FAULT).
- Priority per edge: rst > redirect > normal transitions.
- FETCH: when imem_ready=1, instr_q<=imem_rdata, pc_q<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go to HOLD. When imem_ready=0, stay; pc is unchanged and imem_req stays high.
- HOLD: on out_ready=1, fetch_cnt<=fetch_cnt+1 (wraps) and go to FETCH. When out_ready=0, stay, and the outputs stay stable.
- redirect=1 (state FETCH or HOLD): if redirect_pc[1:0]==0, pc<=redirect_pc and go to FETCH. A memory response in the same cycle is dropped. A held instruction is killed and not counted, even if out_ready=1, because decode treats it as wrong-path. If redirect_pc[1:0]!=0, go to FAULT and leave pc unchanged.
- FAULT: imem_req=0 and out_valid=0. redirect is ignored. Only rst exits.
- Only one memory request is outstanding at a time. Memory must hold imem_rdata valid during the imem_ready cycle only.

## Timing
- Reset (rst high at an edge): pc=RESET_PC, state=FETCH, instr_q=0, pc_q=0, fetch_cnt=0. Resulting outputs: imem_req=1, imem_addr=RESET_PC, out_valid=0, fetch_fault=0.
- Fetch latency: imem_ready seen at edge N gives out_valid=1 from N+1.
- Accept at edge M gives imem_req=1 for pc+4 from M+1. Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect at edge R gives imem_addr=redirect_pc and out_valid=0 from R+1.
- rst mid-fetch or mid-hold: all state is reset at that edge and any pending response is dropped.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0013 at every address: out_pc sequence 0,4,8 on alternating cycles. After 3 accepts, fetch_cnt=3.
- Memory wait states: imem_ready low for 3 cycles at addr 0x10 -> imem_addr stays 0x10 and out_valid stays 0. Then data 32'h00A00093 appears with out_pc=0x10.
- Backpressure: out_ready low for 4 cycles in HOLD -> out_instr/out_pc stable, imem_req=0, fetch_cnt unchanged. Then accept, and fetch_cnt increments by exactly 1.
- Redirect to 0x100 in the same cycle as imem_ready, and separately in HOLD with out_ready=1 -> next imem_addr=0x100, no instruction delivered, fetch_cnt unchanged.
- Redirect to 0x102 -> fetch_fault=1 and imem_req=0 permanently. A later redirect to 0x200 is ignored. rst restores imem_addr=RESET_PC and fetch_fault=0.
- PC wrap: redirect to 32'hFFFF_FFFC, accept one -> next imem_addr=0.
